// File: rtl/ocm_result_writer_pkg.sv
// ---------------------------------------------------------------------------
// ocm_result_writer_pkg
//   Definitions shared by the OCM result writer and its reader counterpart
//   (readOCM):
//     - FSM state encoding for the writer (IDLE / WRITE / DONE)
//     - OCM1 geometry (data width, address width)
//     - default frame geometry: a 28x28 image through a 3x3 valid
//       convolution gives 26x26 = 676 result beats
//     - beat counter width and a small last-beat helper
// ---------------------------------------------------------------------------
package ocm_result_writer_pkg;

  // Writer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  // OCM1 geometry
  localparam int OCM_DW     = 8;
  localparam int OCM_ADDR_W = 17;

  // Frame geometry shared with readOCM
  localparam int IMG_W   = 28;
  localparam int K       = 3;
  localparam int OUT_W   = IMG_W - K + 1;
  localparam int OUT_LEN = OUT_W * OUT_W;

  // Beat counter width (frames of up to 65535 beats)
  localparam int COUNT_W = 16;

  // True when the beat about to be written (index cnt) is the final one
  function automatic logic beat_is_last(input logic [COUNT_W-1:0] cnt,
                                        input logic [COUNT_W-1:0] last_idx);
    return (cnt == last_idx);
  endfunction

endpackage : ocm_result_writer_pkg

// File: rtl/ocm_result_writer_rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
//   0->1 edge detector built around a single history flop. The history flop
//   samples d every cycle; rise = d & ~history, so a rise is reported in the
//   same cycle the input is first seen high.
//   RESET_VAL sets the history value during reset. With RESET_VAL=1 an input
//   already high when reset releases is not treated as an edge; a fresh 0->1
//   transition is required.
// Ports
//   clk   in  1  clock
//   rst   in  1  asynchronous reset, active-high
//   d     in  1  level input
//   rise  out 1  high for the cycle in which d is high and was low last cycle
// ---------------------------------------------------------------------------
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next value of the history flop is simply the current input
  always_comb begin
    prev_d = d;
  end

  // History flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule : rise_detect

// File: rtl/ocm_result_writer.sv
// ---------------------------------------------------------------------------
// ocm_result_writer
//   Sink end of the OCM pixel stream. Takes the CNN datapath result stream
//   (in_data qualified by in_dv, no backpressure) and writes each beat into
//   the OCM1 s1 port at consecutive addresses starting at BASE_ADDR. A frame
//   is FRAME_LEN beats. Progress (count, busy) and completion (done) plus a
//   sticky overflow flag are reported to the HPS PIOs.
//
//   A 0->1 edge on start arms a frame from any state; in WRITE this aborts
//   and restarts the frame at BASE_ADDR. A beat arriving in the same cycle
//   as the start edge becomes beat 0 of the new frame.
//
//   All outputs are registered: a beat accepted in cycle n appears on the
//   OCM1 port (write/chip strobe, address, data) in cycle n+1.
//
// Ports
//   clk             in   1       system clock
//   reset           in   1       asynchronous reset, active-high
//   start           in   1       HPS level; each 0->1 edge (re)arms a frame
//   in_dv           in   1       result beat valid
//   in_data         in   DATA_W  result beat
//   ocm1_addr       out  ADDR_W  OCM1 s1 address
//   ocm1_chip       out  1       OCM1 chipselect (pulses with each write)
//   ocm1_clk_enab   out  1       OCM1 clken (1 whenever out of reset)
//   ocm1_write      out  1       OCM1 write strobe, one cycle per beat
//   ocm1_writedata  out  OCM_DW  OCM1 write data (extended in_data)
//   count           out  16      beats written in the current frame
//   busy            out  1       high while in WRITE
//   done            out  1       sticky, full frame written
//   overflow        out  1       sticky, in_dv seen while in DONE
// ---------------------------------------------------------------------------
module ocm_result_writer
  import ocm_result_writer_pkg::*;
#(
  parameter int DATA_W    = 6,
  parameter int OCM_DW    = ocm_result_writer_pkg::OCM_DW,
  parameter int ADDR_W    = ocm_result_writer_pkg::OCM_ADDR_W,
  parameter int BASE_ADDR = 0,
  parameter int FRAME_LEN = ocm_result_writer_pkg::OUT_LEN,
  parameter int SIGN_EXT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_dv,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] ocm1_addr,
  output logic              ocm1_chip,
  output logic              ocm1_clk_enab,
  output logic              ocm1_write,
  output logic [OCM_DW-1:0] ocm1_writedata,
  output logic [15:0]       count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0]  BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(FRAME_LEN - 1);

  // -------------------------------------------------------------------------
  // Start edge detection. History resets to 1 so that start held high
  // through reset does not arm a frame.
  // -------------------------------------------------------------------------
  logic start_rise_s;

  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_start_rise (
    .clk  (clk),
    .rst  (reset),
    .d    (start),
    .rise (start_rise_s)
  );

  // -------------------------------------------------------------------------
  // Width extension of the result beat into the OCM data word
  // -------------------------------------------------------------------------
  logic [OCM_DW-1:0] ext_s;

  generate
    if (OCM_DW > DATA_W) begin : g_pad
      if (SIGN_EXT != 0) begin : g_sign
        assign ext_s = {{(OCM_DW-DATA_W){in_data[DATA_W-1]}}, in_data};
      end else begin : g_zero
        assign ext_s = {{(OCM_DW-DATA_W){1'b0}}, in_data};
      end
    end else begin : g_same
      assign ext_s = in_data;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  wr_state_e          state_q,    state_d;
  logic [COUNT_W-1:0] count_q,    count_d;
  logic [ADDR_W-1:0]  addr_q,     addr_d;
  logic [OCM_DW-1:0]  wdata_q,    wdata_d;
  logic               write_q,    write_d;
  logic               chip_q,     chip_d;
  logic               clk_enab_q, clk_enab_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               ovf_q,      ovf_d;

  // Next-state and next-output computation for the writer FSM
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = 1'b0;
    chip_d     = 1'b0;
    clk_enab_d = 1'b1;
    done_d     = done_q;
    ovf_d      = ovf_q;

    if (start_rise_s) begin
      // A start edge wins over everything: (re)start the frame from beat 0.
      // A coincident beat is taken as beat 0 of the new frame.
      state_d = ST_WRITE;
      count_d = {COUNT_W{1'b0}};
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      if (in_dv) begin
        write_d = 1'b1;
        chip_d  = 1'b1;
        addr_d  = BASE_A;
        wdata_d = ext_s;
        count_d = {{(COUNT_W-1){1'b0}}, 1'b1};
        if (beat_is_last({COUNT_W{1'b0}}, LAST_IDX)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end else begin
        write_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Beats before a start edge are dropped silently
          state_d = ST_IDLE;
        end
        ST_WRITE: begin
          if (in_dv) begin
            write_d = 1'b1;
            chip_d  = 1'b1;
            addr_d  = BASE_A + ADDR_W'(count_q);
            wdata_d = ext_s;
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            if (beat_is_last(count_q, LAST_IDX)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WRITE;
            end
          end else begin
            // Gap cycle: address and data hold, no strobe
            state_d = ST_WRITE;
          end
        end
        ST_DONE: begin
          // Frame complete: further beats are flagged, never written
          if (in_dv) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // busy tracks the state being entered so it drops with the last strobe
    busy_d = (state_d == ST_WRITE);
  end

  // Register all state and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= {COUNT_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {OCM_DW{1'b0}};
      write_q    <= 1'b0;
      chip_q     <= 1'b0;
      clk_enab_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      chip_q     <= chip_d;
      clk_enab_q <= clk_enab_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ocm1_addr      = addr_q;
  assign ocm1_chip      = chip_q;
  assign ocm1_clk_enab  = clk_enab_q;
  assign ocm1_write     = write_q;
  assign ocm1_writedata = wdata_q;
  assign count          = count_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow       = ovf_q;

endmodule : ocm_result_writer

// File: tb/tb_ocm_result_writer.sv
// ---------------------------------------------------------------------------
// tb_ocm_result_writer
//   Directed bench for ocm_result_writer with default parameters
//   (DATA_W=6, OCM_DW=8, ADDR_W=17, BASE_ADDR=0, FRAME_LEN=676, SIGN_EXT=1).
//   Inputs change 1 time unit after the rising edge; outputs are sampled at
//   the same point, so each sample reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_ocm_result_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_dv;
  logic [5:0]  in_data;
  logic [16:0] ocm1_addr;
  logic        ocm1_chip;
  logic        ocm1_clk_enab;
  logic        ocm1_write;
  logic [7:0]  ocm1_writedata;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ocm_result_writer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_dv          (in_dv),
    .in_data        (in_data),
    .ocm1_addr      (ocm1_addr),
    .ocm1_chip      (ocm1_chip),
    .ocm1_clk_enab  (ocm1_clk_enab),
    .ocm1_write     (ocm1_write),
    .ocm1_writedata (ocm1_writedata),
    .count          (count),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  // 6-bit beat sign-extended to the 8-bit OCM word
  function automatic logic [7:0] ext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

  // Apply one cycle of inputs, then return 1 unit after the next rising edge
  task automatic step(input logic s, input logic dv, input logic [5:0] d);
    start   = s;
    in_dv   = dv;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_dv = 1'b0; in_data = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({ocm1_addr, ocm1_chip, ocm1_clk_enab, ocm1_write, ocm1_writedata, count, busy, done, overflow} !== 47'd0)
      begin miscompares++; $display("FAIL reset_state: got addr=%0d chip=%b ce=%b wr=%b wd=%h cnt=%0d busy=%b done=%b ovf=%b, want all 0",
        ocm1_addr, ocm1_chip, ocm1_clk_enab, ocm1_write, ocm1_writedata, count, busy, done, overflow); end
    reset = 1'b0;
    step(1'b0, 1'b0, 6'd0);
    vectors++;
    if (ocm1_clk_enab !== 1'b1 || busy !== 1'b0 || ocm1_write !== 1'b0)
      begin miscompares++; $display("FAIL post_reset: got ce=%b busy=%b wr=%b, want ce=1 busy=0 wr=0", ocm1_clk_enab, busy, ocm1_write); end
  endtask

  task automatic test_idle_dv();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 6'(i + 7));
      vectors++;
      if (ocm1_write !== 1'b0 || ocm1_chip !== 1'b0 || overflow !== 1'b0 || count !== 16'd0 || busy !== 1'b0)
        begin miscompares++; $display("FAIL idle_dv: got wr=%b chip=%b ovf=%b cnt=%0d busy=%b, want 0 0 0 0 0",
          ocm1_write, ocm1_chip, overflow, count, busy); end
    end
  endtask

  // Full frame from a fresh start edge, optionally with random 0-5 cycle gaps
  task automatic test_frame(input bit gaps);
    int unsigned g;
    logic [5:0]  d;
    step(1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 6'd0);
    vectors++;
    if (busy !== 1'b1 || count !== 16'd0 || done !== 1'b0 || overflow !== 1'b0 || ocm1_write !== 1'b0)
      begin miscompares++; $display("FAIL frame_arm: got busy=%b cnt=%0d done=%b ovf=%b wr=%b, want 1 0 0 0 0",
        busy, count, done, overflow, ocm1_write); end
    for (int i = 0; i < 676; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 5);
        for (int k = 0; k < int'(g); k++) begin
          step(1'b1, 1'b0, 6'h15);
          vectors++;
          if (ocm1_write !== 1'b0 || ocm1_chip !== 1'b0 || count !== 16'(i))
            begin miscompares++; $display("FAIL gap_cycle beat=%0d: got wr=%b chip=%b cnt=%0d, want wr=0 chip=0 cnt=%0d",
              i, ocm1_write, ocm1_chip, count, i); end
        end
      end
      d = 6'(i % 64);
      step(1'b1, 1'b1, d);
      vectors++;
      if (ocm1_write !== 1'b1 || ocm1_chip !== 1'b1 || ocm1_addr !== 17'(i) ||
          ocm1_writedata !== ext6(d) || count !== 16'(i + 1))
        begin miscompares++; $display("FAIL beat_write i=%0d: got wr=%b chip=%b addr=%0d wd=%h cnt=%0d, want 1 1 addr=%0d wd=%h cnt=%0d",
          i, ocm1_write, ocm1_chip, ocm1_addr, ocm1_writedata, count, i, ext6(d), i + 1); end
      if (i == 31) begin
        vectors++;
        if (ocm1_writedata !== 8'h1F)
          begin miscompares++; $display("FAIL ext_pos: got %h want 1f", ocm1_writedata); end
      end
      if (i == 63) begin
        vectors++;
        if (ocm1_writedata !== 8'hFF)
          begin miscompares++; $display("FAIL ext_neg: got %h want ff", ocm1_writedata); end
      end
      if (i == 674) begin
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1)
          begin miscompares++; $display("FAIL before_last: got done=%b busy=%b want done=0 busy=1", done, busy); end
      end
    end
    // Sample here shows the last strobe together with done
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 16'd676 || overflow !== 1'b0)
      begin miscompares++; $display("FAIL frame_done: got done=%b busy=%b cnt=%0d ovf=%b, want 1 0 676 0",
        done, busy, count, overflow); end
    step(1'b1, 1'b0, 6'd0);
    vectors++;
    if (ocm1_write !== 1'b0 || done !== 1'b1 || count !== 16'd676)
      begin miscompares++; $display("FAIL after_done: got wr=%b done=%b cnt=%0d, want 0 1 676", ocm1_write, done, count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 6'h2A);
      vectors++;
      if (ocm1_write !== 1'b0 || ocm1_chip !== 1'b0 || overflow !== 1'b1 || count !== 16'd676 || done !== 1'b1)
        begin miscompares++; $display("FAIL overflow_beat %0d: got wr=%b chip=%b ovf=%b cnt=%0d done=%b, want 0 0 1 676 1",
          i, ocm1_write, ocm1_chip, overflow, count, done); end
    end
    step(1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 6'd0);
    vectors++;
    if (done !== 1'b0 || overflow !== 1'b0 || count !== 16'd0 || busy !== 1'b1)
      begin miscompares++; $display("FAIL rearm_clear: got done=%b ovf=%b cnt=%0d busy=%b, want 0 0 0 1",
        done, overflow, count, busy); end
  endtask

  // Entered in WRITE with count 0 and start high
  task automatic test_restart_mid();
    for (int i = 0; i < 300; i++) begin
      // drop start on beat 299 so beat 300 can carry a fresh edge
      step((i == 299) ? 1'b0 : 1'b1, 1'b1, 6'(i % 64));
      vectors++;
      if (ocm1_write !== 1'b1 || ocm1_addr !== 17'(i) || count !== 16'(i + 1))
        begin miscompares++; $display("FAIL pre_restart i=%0d: got wr=%b addr=%0d cnt=%0d, want 1 %0d %0d",
          i, ocm1_write, ocm1_addr, count, i, i + 1); end
    end
    step(1'b1, 1'b1, 6'd44);
    vectors++;
    if (ocm1_write !== 1'b1 || ocm1_addr !== 17'd0 || ocm1_writedata !== 8'hEC || count !== 16'd1 || busy !== 1'b1)
      begin miscompares++; $display("FAIL restart_beat: got wr=%b addr=%0d wd=%h cnt=%0d busy=%b, want 1 0 ec 1 1",
        ocm1_write, ocm1_addr, ocm1_writedata, count, busy); end
    for (int j = 1; j < 676; j++) begin
      step(1'b1, 1'b1, 6'((300 + j) % 64));
      vectors++;
      if (ocm1_write !== 1'b1 || ocm1_addr !== 17'(j) || ocm1_writedata !== ext6(6'((300 + j) % 64)) || count !== 16'(j + 1))
        begin miscompares++; $display("FAIL post_restart j=%0d: got wr=%b addr=%0d wd=%h cnt=%0d, want 1 %0d %h %0d",
          j, ocm1_write, ocm1_addr, ocm1_writedata, count, j, ext6(6'((300 + j) % 64)), j + 1); end
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 16'd676)
      begin miscompares++; $display("FAIL restart_done: got done=%b busy=%b cnt=%0d, want 1 0 676", done, busy, count); end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 6'(i % 64));
    vectors++;
    if (count !== 16'd100 || ocm1_addr !== 17'd99)
      begin miscompares++; $display("FAIL before_reset: got cnt=%0d addr=%0d, want 100 99", count, ocm1_addr); end
    // Beat 100 is presented, reset hits mid-cycle before the next edge
    start = 1'b1; in_dv = 1'b1; in_data = 6'd36;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({ocm1_addr, ocm1_chip, ocm1_clk_enab, ocm1_write, ocm1_writedata, count, busy, done, overflow} !== 47'd0)
      begin miscompares++; $display("FAIL async_reset: got addr=%0d chip=%b ce=%b wr=%b wd=%h cnt=%0d busy=%b done=%b ovf=%b, want all 0",
        ocm1_addr, ocm1_chip, ocm1_clk_enab, ocm1_write, ocm1_writedata, count, busy, done, overflow); end
    step(1'b1, 1'b1, 6'd37);
    step(1'b1, 1'b0, 6'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 6'd5);
      vectors++;
      if (ocm1_write !== 1'b0 || busy !== 1'b0 || count !== 16'd0 || ocm1_clk_enab !== 1'b1)
        begin miscompares++; $display("FAIL held_start_no_arm %0d: got wr=%b busy=%b cnt=%0d ce=%b, want 0 0 0 1",
          i, ocm1_write, busy, count, ocm1_clk_enab); end
    end
    step(1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 6'd0);
    vectors++;
    if (busy !== 1'b1 || count !== 16'd0)
      begin miscompares++; $display("FAIL fresh_edge_arm: got busy=%b cnt=%0d, want 1 0", busy, count); end
  endtask

  initial begin
    test_reset();
    test_idle_dv();
    test_frame(1'b0);
    test_frame(1'b1);
    test_overflow();
    test_restart_mid();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ocm_result_writer
